// File: rtl/datapath_pkg.sv
// Shared datapath types and select encodings for the word-select stages.
package datapath_pkg;

    localparam int DATA_W = 16;

    typedef logic [DATA_W-1:0] word_t;

    localparam logic SEL_A = 1'b0;
    localparam logic SEL_B = 1'b1;

endpackage : datapath_pkg

// File: rtl/mux2_word.sv
// Combinational 2:1 word multiplexer; sel chooses b when high, a when low.
module mux2_word
    import datapath_pkg::*;
#(
    parameter int WIDTH = DATA_W
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sel,
    output logic [WIDTH-1:0] y
);

    always_comb begin
        y = a;
        if (sel == SEL_B) begin
            y = b;
        end
    end

endmodule : mux2_word

// File: rtl/mux16_sel_reg.sv
// Registered 2:1 word select stage with capture enable and a one-cycle valid flag.
module mux16_sel_reg
    import datapath_pkg::*;
#(
    parameter int               WIDTH     = DATA_W,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sel,
    output logic [WIDTH-1:0] out,
    output logic             out_valid
);

    logic [WIDTH-1:0] mux_d;
    logic [WIDTH-1:0] out_q;
    logic [WIDTH-1:0] out_d;
    logic             valid_q;
    logic             valid_d;

    mux2_word #(
        .WIDTH (WIDTH)
    ) u_mux (
        .a   (a),
        .b   (b),
        .sel (sel),
        .y   (mux_d)
    );

    // The valid flag marks only the cycle right after a capture; holding the word does not keep it high.
    always_comb begin
        out_d   = out_q;
        valid_d = 1'b0;
        if (en) begin
            out_d   = mux_d;
            valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_q   <= RESET_VAL;
            valid_q <= 1'b0;
        end else begin
            out_q   <= out_d;
            valid_q <= valid_d;
        end
    end

    assign out       = out_q;
    assign out_valid = valid_q;

endmodule : mux16_sel_reg

// File: tb/tb_mux16_sel_reg.sv
// Directed and randomized checks of mux16_sel_reg against a behavioural reference model.
module tb_mux16_sel_reg;
    import datapath_pkg::*;

    logic  clk = 1'b0;
    logic  rst;
    logic  en;
    word_t a;
    word_t b;
    logic  sel;
    word_t out;
    logic  out_valid;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state: what the registered outputs should hold after the last edge.
    word_t exp_out;
    logic  exp_valid;

    mux16_sel_reg #(
        .WIDTH     (16),
        .RESET_VAL (16'h0000)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .a         (a),
        .b         (b),
        .sel       (sel),
        .out       (out),
        .out_valid (out_valid)
    );

    always #5 clk = ~clk;

    task automatic check_word(input string tag, input word_t obs, input word_t expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic check_bit(input string tag, input logic obs, input logic expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %b expected %b", tag, obs, expv);
        end
    endtask

    // Drive one cycle's inputs away from the edge, let the edge happen, then
    // advance the model and compare both outputs just after the edge.
    task automatic step(input string tag, input logic r, input logic e,
                        input word_t va, input word_t vb, input logic s);
        @(negedge clk);
        rst = r;
        en  = e;
        a   = va;
        b   = vb;
        sel = s;
        @(posedge clk);
        #1;
        if (r) begin
            exp_out   = 16'h0000;
            exp_valid = 1'b0;
        end else if (e) begin
            exp_out   = s ? vb : va;
            exp_valid = 1'b1;
        end else begin
            exp_valid = 1'b0;
        end
        check_word({tag, ".out"}, out, exp_out);
        check_bit({tag, ".valid"}, out_valid, exp_valid);
        // Wiggle the inputs between edges; the next edge must not see these.
        a   = ~va;
        b   = ~vb;
        sel = ~s;
    endtask

    function automatic word_t rand_word();
        case ($urandom_range(0, 7))
            0:       return 16'hFFFF;
            1:       return 16'h0000;
            default: return word_t'($urandom);
        endcase
    endfunction

    initial begin
        word_t ra;
        word_t rb;
        rst = 1'b1; en = 1'b1; a = 16'hAAAA; b = 16'h5555; sel = 1'b1;
        exp_out = 16'h0000; exp_valid = 1'b0;

        step("reset0", 1'b1, 1'b1, 16'hAAAA, 16'h5555, 1'b1);
        step("reset1", 1'b1, 1'b1, 16'hAAAA, 16'h5555, 1'b1);
        check_word("reset_const", out, 16'h0000);

        step("basic_a", 1'b0, 1'b1, 16'hAAAA, 16'h5555, 1'b0);
        check_word("basic_a_const", out, 16'hAAAA);
        check_bit("basic_a_valid_const", out_valid, 1'b1);
        step("basic_b", 1'b0, 1'b1, 16'hAAAA, 16'h5555, 1'b1);
        check_word("basic_b_const", out, 16'h5555);

        step("new_a", 1'b0, 1'b1, 16'h1234, 16'h5678, 1'b0);
        check_word("new_a_const", out, 16'h1234);
        step("new_b", 1'b0, 1'b1, 16'h1234, 16'h5678, 1'b1);
        check_word("new_b_const", out, 16'h5678);
        for (int i = 0; i < 4; i++) begin
            step("toggle", 1'b0, 1'b1, 16'h1234, 16'h5678, i[0]);
            check_word("toggle_const", out, i[0] ? 16'h5678 : 16'h1234);
        end

        for (int i = 0; i < 3; i++) begin
            step("hold", 1'b0, 1'b0, 16'hFFFF, 16'h0001, i[0]);
            check_word("hold_const", out, 16'h5678);
            check_bit("hold_valid_const", out_valid, 1'b0);
        end

        step("beef_pre", 1'b0, 1'b1, 16'h0000, 16'hBEEF, 1'b1);
        check_word("beef_pre_const", out, 16'hBEEF);
        step("mid_reset", 1'b1, 1'b1, 16'h0000, 16'hBEEF, 1'b1);
        check_word("mid_reset_const", out, 16'h0000);
        step("beef_post", 1'b0, 1'b1, 16'h0000, 16'hBEEF, 1'b1);
        check_word("beef_post_const", out, 16'hBEEF);

        for (int i = 0; i < 1000; i++) begin
            ra = rand_word();
            rb = ($urandom_range(0, 9) == 0) ? ra : rand_word();
            step("random", ($urandom_range(0, 99) < 2), 1'($urandom), ra, rb, 1'($urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_mux16_sel_reg
